// File: rtl/lsu_bus_if.sv
// Data-bus channel between the load/store unit and memory.
// The master side (LSU) drives the request; the slave side (memory) returns ack and read data.
interface lsu_bus_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_wdata_o,
        output bus_wstrb_o,
        input  bus_ack_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        input  bus_wstrb_o,
        output bus_ack_i,
        output bus_rdata_i
    );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter.
// Takes one load or store from execute, checks alignment, issues a single word-aligned
// bus transaction with byte strobes, waits for ack (or times out), then writes back the
// extended load result for one cycle. The pipeline is held while a transaction is in flight.
module lsu_bus #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_raddr_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  byte_sel_i,
    input  logic        un_sign_i,
    input  logic [4:0]  rd_waddr_i,

    lsu_bus_if.master   bus,

    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic        hold_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Normalised access sizes; byte_sel 11 folds into word.
    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Captured request
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsign_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Completion results
    logic [31:0] rdata_q;
    logic        rd_we_q;
    logic        misalign_q;
    logic        timeout_q;

    // Request decode
    logic        req;
    logic        is_store;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        misaligned;
    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;

    // Bus-side decode
    logic        ack_hit;
    logic        ack_timeout;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // Decode the incoming request and check alignment.
    always_comb begin
        req      = mem_re_i | mem_we_i;
        is_store = mem_we_i;
        req_addr = is_store ? mem_waddr_i : mem_raddr_i;
        req_size = (byte_sel_i == 2'b11) ? SzWord : byte_sel_i;

        misaligned = 1'b0;
        if (req_size == SzHalf && req_addr[0]) begin
            misaligned = 1'b1;
        end
        if (req_size == SzWord && req_addr[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end

        accept = (state_q == StIdle) && req && !misaligned;
    end

    // Build the lane-replicated store data and byte strobes; loads carry no strobes.
    always_comb begin
        lane_wdata = 32'h0;
        lane_wstrb = 4'b0000;
        if (is_store) begin
            unique case (req_size)
                SzByte: begin
                    lane_wdata = {4{mem_wdata_i[7:0]}};
                    lane_wstrb = 4'b0001 << req_addr[1:0];
                end
                SzHalf: begin
                    lane_wdata = {2{mem_wdata_i[15:0]}};
                    lane_wstrb = 4'b0011 << req_addr[1:0];
                end
                default: begin
                    lane_wdata = mem_wdata_i;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Pick the addressed byte/halfword out of the read word and extend it.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    load_byte = bus.bus_rdata_i[7:0];
            2'd1:    load_byte = bus.bus_rdata_i[15:8];
            2'd2:    load_byte = bus.bus_rdata_i[23:16];
            default: load_byte = bus.bus_rdata_i[31:24];
        endcase
        load_half = addr_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];

        unique case (size_q)
            SzByte:  load_ext = {{24{load_byte[7] & ~unsign_q}}, load_byte};
            SzHalf:  load_ext = {{16{load_half[15] & ~unsign_q}}, load_half};
            default: load_ext = bus.bus_rdata_i;
        endcase
    end

    // Ack only counts while a transaction is outstanding; ack beats the timeout.
    always_comb begin
        ack_hit     = (state_q == StBusy) && bus.bus_ack_i;
        ack_timeout = (state_q == StBusy) && !bus.bus_ack_i && (cnt_q == CntLast);
    end

    // Next-state and timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    cnt_d   = 8'd0;
                end
            end
            StBusy: begin
                if (ack_hit || ack_timeout) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                // The finishing instruction is still presented upstream; never re-accept here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on accept so the bus sees stable values throughout BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            size_q   <= SzByte;
            unsign_q <= 1'b0;
            rd_q     <= 5'd0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'b0000;
        end else if (accept) begin
            addr_q   <= req_addr;
            we_q     <= is_store;
            size_q   <= req_size;
            unsign_q <= un_sign_i;
            rd_q     <= rd_waddr_i;
            wdata_q  <= lane_wdata;
            wstrb_q  <= lane_wstrb;
        end
    end

    // Latch the completion result; write-back is only armed for an acked load to a real register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
            rd_we_q <= 1'b0;
        end else if (ack_hit || ack_timeout) begin
            rdata_q <= ack_hit ? load_ext : 32'h0;
            rd_we_q <= ack_hit && !we_q && (rd_q != 5'd0);
        end
    end

    // One-cycle status pulses, raised the cycle after the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            misalign_q <= (state_q == StIdle) && req && misaligned;
            timeout_q  <= ack_timeout;
        end
    end

    // Output drive; hold is raised combinationally on accept but forced low under reset.
    always_comb begin
        bus.bus_req_o   = (state_q == StBusy);
        bus.bus_we_o    = we_q;
        bus.bus_addr_o  = {addr_q[31:2], 2'b00};
        bus.bus_wdata_o = wdata_q;
        bus.bus_wstrb_o = wstrb_q;

        hold_o     = (state_q == StBusy) || (accept && !rst);
        rd_we_o    = (state_q == StDone) && rd_we_q;
        rd_waddr_o = rd_q;
        rd_wdata_o = rdata_q;
        misalign_o = misalign_q;
        timeout_o  = timeout_q;
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Randomised bench for lsu_bus: each transaction is scored against an arithmetic model of
// the alignment, lane and extension rules, with a memory responder acking on a chosen cycle.
module tb_lsu_bus;

    localparam int AckTimeout = 16;

    logic        clk;
    logic        rst;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [1:0]  byte_sel_i;
    logic        un_sign_i;
    logic [4:0]  rd_waddr_i;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    logic        hold_o;
    logic        misalign_o;
    logic        timeout_o;

    int n_checks;
    int n_errors;

    lsu_bus_if bif ();

    lsu_bus #(
        .ACK_TIMEOUT (AckTimeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_i    (mem_re_i),
        .mem_we_i    (mem_we_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .byte_sel_i  (byte_sel_i),
        .un_sign_i   (un_sign_i),
        .rd_waddr_i  (rd_waddr_i),
        .bus         (bif),
        .rd_we_o     (rd_we_o),
        .rd_waddr_o  (rd_waddr_o),
        .rd_wdata_o  (rd_wdata_o),
        .hold_o      (hold_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from a negedge and follows it to completion.
    // ack_at: BUSY cycle (1-based) on which memory acks; outside 1..AckTimeout means never.
    task automatic run_txn(input logic re, input logic we, input logic [31:0] raddr,
                           input logic [31:0] waddr, input logic [31:0] wdata,
                           input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
        logic [31:0] a;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_load;
        longint      v;
        int          nb;
        int          ackc;
        bit          store;
        bit          mis;
        bit          tmo;
        bit          exp_rdwe;

        store = we;
        a     = store ? waddr : raddr;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis   = (a % nb) != 0;
        exp_strb = store ? 4'(((1 << nb) - 1) << a[1:0]) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
        end
        v = (longint'(rdata) >> (8 * a[1:0])) & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) begin
            v = v - (longint'(1) << (8 * nb));
        end
        exp_load = v[31:0];
        ackc     = (ack_at >= 1 && ack_at <= AckTimeout) ? ack_at : 0;
        tmo      = (ackc == 0);
        exp_rdwe = !store && !tmo && (rd != 5'd0);

        mem_re_i = re;  mem_we_i = we;  mem_raddr_i = raddr;  mem_waddr_i = waddr;
        mem_wdata_i = wdata;  byte_sel_i = sz;  un_sign_i = uns;  rd_waddr_i = rd;
        #1;
        check("accept_hold", 32'(hold_o), 32'(!mis));
        check("accept_req", 32'(bif.bus_req_o), 32'd0);

        if (mis) begin
            @(negedge clk);
            mem_re_i = 1'b0;  mem_we_i = 1'b0;
            #1;
            check("mis_pulse", 32'(misalign_o), 32'd1);
            check("mis_req", 32'(bif.bus_req_o), 32'd0);
            check("mis_hold", 32'(hold_o), 32'd0);
            @(negedge clk);
            #1;
            check("mis_pulse_end", 32'(misalign_o), 32'd0);
            check("mis_req_after", 32'(bif.bus_req_o), 32'd0);
            return;
        end

        for (int c = 1; c <= AckTimeout; c++) begin
            @(negedge clk);
            bif.bus_ack_i   = (c == ackc);
            bif.bus_rdata_i = (c == ackc) ? rdata : $urandom;
            #1;
            check("busy_req", 32'(bif.bus_req_o), 32'd1);
            check("busy_hold", 32'(hold_o), 32'd1);
            check("busy_addr", bif.bus_addr_o, {a[31:2], 2'b00});
            check("busy_we", 32'(bif.bus_we_o), 32'(store));
            check("busy_strb", 32'(bif.bus_wstrb_o), 32'(exp_strb));
            if (store) check("busy_wdata", bif.bus_wdata_o, exp_wdata);
            if (c == ackc) break;
        end

        // DONE: a stray ack here must be ignored
        @(negedge clk);
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = $urandom;
        #1;
        check("done_req", 32'(bif.bus_req_o), 32'd0);
        check("done_hold", 32'(hold_o), 32'd0);
        check("done_timeout", 32'(timeout_o), 32'(tmo));
        check("done_rd_we", 32'(rd_we_o), 32'(exp_rdwe));
        if (exp_rdwe) begin
            check("done_rd_addr", 32'(rd_waddr_o), 32'(rd));
            check("done_rd_data", rd_wdata_o, exp_load);
        end

        @(negedge clk);
        bif.bus_ack_i = 1'b0;
        mem_re_i = 1'b0;  mem_we_i = 1'b0;
        #1;
        check("idle_req", 32'(bif.bus_req_o), 32'd0);
        check("idle_rd_we", 32'(rd_we_o), 32'd0);
        check("idle_timeout", 32'(timeout_o), 32'd0);
        check("idle_hold", 32'(hold_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(bif.bus_req_o), 32'd0);
        check({tag, "_we"}, 32'(bif.bus_we_o), 32'd0);
        check({tag, "_addr"}, bif.bus_addr_o, 32'd0);
        check({tag, "_wstrb"}, 32'(bif.bus_wstrb_o), 32'd0);
        check({tag, "_hold"}, 32'(hold_o), 32'd0);
        check({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
        check({tag, "_misalign"}, 32'(misalign_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        mem_re_i = 1'b0;  mem_we_i = 1'b0;  mem_raddr_i = '0;  mem_waddr_i = '0;
        mem_wdata_i = '0;  byte_sel_i = '0;  un_sign_i = 1'b0;  rd_waddr_i = '0;
        bif.bus_ack_i = 1'b0;  bif.bus_rdata_i = '0;

        repeat (2) @(negedge clk);
        mem_re_i = 1'b1;  byte_sel_i = 2'b10;
        #1;
        check_all_zero("reset");
        mem_re_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // lw, ack on 3rd BUSY cycle
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 2'b10, 1'b0, 5'd3, 3, 32'hDEADBEEF);
        // lb / lbu at byte 3
        run_txn(1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 2'b00, 1'b0, 5'd4, 1, 32'h80FFFFFF);
        run_txn(1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 2'b00, 1'b1, 5'd4, 2, 32'h80FFFFFF);
        // sh upper half
        run_txn(1'b0, 1'b1, 32'h0, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 5'd7, 2, 32'h0);
        // misaligned lw
        run_txn(1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 2'b10, 1'b0, 5'd1, 1, 32'h0);
        // no ack -> timeout; ack on cycle 15 and on the boundary cycle 16
        run_txn(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 2'b10, 1'b0, 5'd9, 0, 32'h12345678);
        run_txn(1'b1, 1'b0, 32'h404, 32'h0, 32'h0, 2'b10, 1'b0, 5'd9, 15, 32'h12345678);
        run_txn(1'b1, 1'b0, 32'h408, 32'h0, 32'h0, 2'b10, 1'b0, 5'd9, 16, 32'hCAFEF00D);
        // both strobes -> store wins; load to x0 never writes back
        run_txn(1'b1, 1'b1, 32'h500, 32'h601, 32'h000000A5, 2'b00, 1'b0, 5'd2, 1, 32'h0);
        run_txn(1'b1, 1'b0, 32'h700, 32'h0, 32'h0, 2'b11, 1'b0, 5'd0, 1, 32'h11111111);

        // reset in the middle of BUSY
        mem_re_i = 1'b1;  mem_raddr_i = 32'h300;  byte_sel_i = 2'b10;  rd_waddr_i = 5'd5;
        @(negedge clk);
        #1;
        check("pre_rst_req", 32'(bif.bus_req_o), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        mem_re_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 2'b10, 1'b0, 5'd5, 2, 32'h0BADC0DE);

        for (int i = 0; i < 200; i++) begin
            logic re, we;
            logic [31:0] ra, wa;
            logic [4:0] rd;
            re = 1'($urandom);
            we = 1'($urandom);
            if (!re && !we) re = 1'b1;
            ra = $urandom;
            wa = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                ra[1:0] = 2'b00;
                wa[1:0] = 2'b00;
            end
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_txn(re, we, ra, wa, $urandom, 2'($urandom), 1'($urandom), rd,
                    $urandom_range(1, AckTimeout + 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
